uart_rx_fifo: RTL

Serial receive front end for the HACK system. It sits between the `UART_RX` pad and the CPU's memory-mapped UART register. It deserialises 8N1 frames, rejects start-bit glitches and flags framing errors. Received bytes are buffered in a first-word-fall-through FIFO, so the CPU can poll at its own pace without losing characters.

---
 rtl/uart_rx_fifo.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//
// Serial receive front end: deserialises 8N1 frames from the RX pad, rejects
// start-bit glitches, flags framing errors and buffers received bytes in a
// first-word-fall-through queue that the CPU polls at its own pace.
//
// Build option (macro UART_RX_FIFO_EN):
//   defined   - full FIFO of 2^DEPTH_LOG2 entries.
//   undefined - a single holding register replaces the FIFO; COUNT is 0 or 1
//               and FULL is asserted whenever a byte is held.
//
// Parameters:
//   CLKS_PER_BIT  CLK cycles per serial bit (868 = 100 MHz / 115200 baud)
//   DEPTH_LOG2    log2 of FIFO depth (ignored without UART_RX_FIFO_EN)
//
// Ports:
//   CLK        in   system clock, rising edge
//   RST_N      in   asynchronous active-low reset, clears all state
//   RX         in   serial input, asynchronous to CLK, idle high
//   RD         in   pop strobe, one cycle wide, ignored while EMPTY
//   CLR_ERR    in   clears OVERRUN and FRAME_ERR (a same-cycle set wins)
//   DATA       out  head byte, 0x00 while EMPTY
//   EMPTY      out  no bytes held
//   FULL       out  queue holds its maximum number of bytes
//   COUNT      out  number of bytes held
//   OVERRUN    out  sticky: a byte was dropped because the queue was full
//   FRAME_ERR  out  sticky: a stop bit was sampled low
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  RX,
  input  logic                  RD,
  input  logic                  CLR_ERR,
  output logic [7:0]            DATA,
  output logic                  EMPTY,
  output logic                  FULL,
  output logic [DEPTH_LOG2:0]   COUNT,
  output logic                  OVERRUN,
  output logic                  FRAME_ERR
);

  localparam int TMR_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;
  localparam logic [TMR_W-1:0] BIT_END  = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [TMR_W-1:0] HALF_END = TMR_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [DEPTH_LOG2:0] CNT_ONE = (DEPTH_LOG2+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  // ---------------------------------------------------------------------------
  // RX synchroniser. Resets to the idle level so a reset never looks like a
  // start bit.
  // ---------------------------------------------------------------------------
  logic rx_meta, rx_s;

  // NOTE: sequential state is always updated with non-blocking assignments so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_s    <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             push;      // completed byte, valid stop bit
  logic             fe_set;    // stop bit sampled low

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q + TMR_ONE;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    push    = 1'b0;
    fe_set  = 1'b0;

    case (state_q)
      S_IDLE: begin
        tmr_d = '0;
        if (!rx_s) state_d = S_START;
      end

      // Re-check the line at the centre of the start bit; a high sample means
      // the falling edge was a glitch and is silently ignored.
      S_START: begin
        if (tmr_q == HALF_END) begin
          tmr_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end
      end

      // Timer is now aligned to bit centres; shift LSB-first.
      S_DATA: begin
        if (tmr_q == BIT_END) begin
          tmr_d   = '0;
          shreg_d = {rx_s, shreg_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end
      end

      S_STOP: begin
        if (tmr_q == BIT_END) begin
          tmr_d = '0;
          if (rx_s) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            fe_set  = 1'b1;
            state_d = S_WAIT_IDLE;
          end
        end
      end

      // A held-low line (break) yields exactly one error: wait for idle
      // before hunting for another start bit.
      S_WAIT_IDLE: begin
        tmr_d = '0;
        if (rx_s) state_d = S_IDLE;
      end

      default: begin
        tmr_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Receive buffer
  // ---------------------------------------------------------------------------
  logic                pop;       // RD accepted (buffer non-empty)
  logic                wr_en;     // byte accepted into the buffer
  logic                ovr_set;   // byte dropped, buffer full
  logic [DEPTH_LOG2:0] count_q;

`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;

  // A pop in the same cycle frees a slot, so a push into a full FIFO is
  // still accepted when RD is present.
  assign pop     = RD && (count_q != '0);
  assign wr_en   = push && ((count_q != CNT_FULL) || pop);
  assign ovr_set = push && !wr_en;

  // NOTE: the storage array has no reset; its contents are unobservable until
  // written because DATA is forced to zero while the FIFO is empty.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr] <= shreg_q;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !pop)      count_q <= count_q + CNT_ONE;
      else if (pop && !wr_en) count_q <= count_q - CNT_ONE;
    end
  end

  assign DATA = (count_q == '0) ? 8'h00 : mem[rd_ptr];
`else
  localparam logic [DEPTH_LOG2:0] CNT_FULL = CNT_ONE;

  logic [7:0] hold_q;
  logic       valid_q;

  assign pop     = RD && valid_q;
  assign wr_en   = push && (!valid_q || pop);
  assign ovr_set = push && !wr_en;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hold_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (wr_en) begin
        hold_q  <= shreg_q;
        valid_q <= 1'b1;
      end else if (pop) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign count_q = {{DEPTH_LOG2{1'b0}}, valid_q};
  assign DATA    = valid_q ? hold_q : 8'h00;
`endif

  assign COUNT = count_q;
  assign EMPTY = (count_q == '0);
  assign FULL  = (count_q == CNT_FULL);

  // ---------------------------------------------------------------------------
  // Sticky error flags; a new event in the CLR_ERR cycle keeps the flag set.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      OVERRUN   <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      OVERRUN   <= ovr_set | (OVERRUN   & ~CLR_ERR);
      FRAME_ERR <= fe_set  | (FRAME_ERR & ~CLR_ERR);
    end
  end

endmodule
